// File: rtl/i2c_multi_write.sv
// I2C master write engine: shifts frames onto SDA against an externally owned SCL,
// collects slave ACKs and reports arbitration loss and misplaced START/STOP.
module i2c_multi_write #(
  parameter int DATA_W    = 8,
  parameter int CHECK_ARB = 1,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  input  logic              tx_last,
  output logic              tx_ready,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_o,
  output logic              scl_hold,
  output logic              busy,
  output logic              done,
  output logic              nack,
  output logic              arb_lost,
  output logic              bus_err,
  output logic [CNT_W-1:0]  byte_cnt
);

  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BCW-1:0]   BIT_LAST = BCW'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    DATA = 3'd2,
    ACK  = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              scl_last_q, sda_last_q;
  logic [DATA_W-1:0] shift_q, shift_d, shift_nxt;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic              last_q, last_d;
  logic              ack_q, ack_d;
  logic              sda_q, sda_d;
  logic              nack_q, nack_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic              done_q, done_d;
  logic              arb_q, arb_d;
  logic              berr_q, berr_d;
  logic              ready_q, busy_q;
  logic              scl_rise, scl_fall, sda_edge, bus_cond;

  assign scl_rise  = ~scl_last_q & scl_i;
  assign scl_fall  = scl_last_q & ~scl_i;
  assign sda_edge  = sda_last_q ^ sda_i;
  // SDA moving while SCL stays high is a START or STOP from someone else
  assign bus_cond  = scl_last_q & scl_i & sda_edge;
  assign shift_nxt = shift_q << 1'b1;

  // Next-state, datapath and pulse decode
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    last_d     = last_q;
    ack_d      = ack_q;
    sda_d      = 1'b1;
    nack_d     = nack_q;
    byte_cnt_d = byte_cnt_q;
    done_d     = 1'b0;
    arb_d      = 1'b0;
    berr_d     = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!scl_i) begin
            state_d    = LOAD;
            nack_d     = 1'b0;
            byte_cnt_d = {CNT_W{1'b0}};
          end else begin
            state_d = IDLE;
          end
        end
        LOAD: begin
          if (scl_rise) begin
            berr_d  = 1'b1;
            state_d = IDLE;
          end else if (tx_valid) begin
            shift_d   = tx_data;
            last_d    = tx_last;
            bit_cnt_d = BIT_LAST;
            sda_d     = tx_data[DATA_W-1];
            state_d   = DATA;
          end else begin
            state_d = LOAD;
          end
        end
        DATA: begin
          if (bus_cond) begin
            berr_d  = 1'b1;
            state_d = IDLE;
          end else if ((CHECK_ARB != 0) && scl_rise && sda_q && !sda_i) begin
            arb_d   = 1'b1;
            state_d = IDLE;
          end else if (scl_fall) begin
            if (bit_cnt_q == {BCW{1'b0}}) begin
              state_d = ACK;
            end else begin
              shift_d   = shift_nxt;
              bit_cnt_d = bit_cnt_q - BCW'(1);
              sda_d     = shift_nxt[DATA_W-1];
            end
          end else if (!scl_i) begin
            sda_d = shift_q[DATA_W-1];
          end else begin
            sda_d = sda_q;
          end
        end
        ACK: begin
          if (bus_cond) begin
            berr_d  = 1'b1;
            state_d = IDLE;
          end else if (scl_rise) begin
            ack_d = sda_i;
          end else if (scl_fall) begin
            if (!ack_q) begin
              if (byte_cnt_q != CNT_MAX) begin
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
              end else begin
                byte_cnt_d = byte_cnt_q;
              end
              if (last_q) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                state_d = LOAD;
              end
            end else begin
              nack_d  = 1'b1;
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            state_d = ACK;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers; SDA released asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      scl_last_q <= 1'b1;
      sda_last_q <= 1'b1;
      shift_q    <= {DATA_W{1'b0}};
      bit_cnt_q  <= {BCW{1'b0}};
      last_q     <= 1'b0;
      ack_q      <= 1'b0;
      sda_q      <= 1'b1;
      nack_q     <= 1'b0;
      byte_cnt_q <= {CNT_W{1'b0}};
      done_q     <= 1'b0;
      arb_q      <= 1'b0;
      berr_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_last_q <= scl_i;
      sda_last_q <= sda_i;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      last_q     <= last_d;
      ack_q      <= ack_d;
      sda_q      <= sda_d;
      nack_q     <= nack_d;
      byte_cnt_q <= byte_cnt_d;
      done_q     <= done_d;
      arb_q      <= arb_d;
      berr_q     <= berr_d;
      ready_q    <= (state_d == LOAD);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign sda_o    = sda_q;
  assign tx_ready = ready_q;
  assign scl_hold = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign nack     = nack_q;
  assign arb_lost = arb_q;
  assign bus_err  = berr_q;
  assign byte_cnt = byte_cnt_q;

endmodule
